ddr3_traffic_checker: RTL and testbench

//  Synthesisable write-then-read traffic generator/checker for the slowDDR3 user (sysIO_*) interface.

---
 rtl/ddr3_traffic_checker_pkg.sv | 29 ++
 rtl/ddr3_traffic_checker_pattern_gen.sv | 54 +++++
 rtl/ddr3_traffic_checker.sv | 168 ++++++++++++++++
 tb/tb_ddr3_traffic_checker.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_traffic_checker_pkg.sv
// Shared state encoding, pattern selectors and LFSR feedback masks for the
// DDR3 write-then-read traffic checker.
package ddr3_tc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_INIT,
        ST_WRITE,
        ST_READ,
        ST_DONE
    } state_t;

    localparam int PAT_INC  = 0;
    localparam int PAT_LFSR = 1;
    localparam int PAT_XOR  = 2;

    // Right-shifting Galois feedback masks giving maximal-length sequences
    function automatic logic [63:0] lfsr_taps(input int width);
        logic [63:0] taps;
        case (width)
            8:       taps = 64'h0000_0000_0000_00B8;
            32:      taps = 64'h0000_0000_8020_0003;
            64:      taps = 64'hD800_0000_0000_0000;
            default: taps = 64'h0000_0000_0000_B400;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/ddr3_traffic_checker_pattern_gen.sv
// Data word generator shared by the write and read phases; restarting it at
// each phase entry makes the read phase replay the written sequence exactly.
module ddr3_pattern_gen
    import ddr3_tc_pkg::*;
#(
    parameter int          DATA_W    = 16,
    parameter int          PATTERN   = PAT_INC,
    parameter logic [63:0] BASE_ADDR = 64'd0,
    parameter logic [63:0] SEED      = 64'hACE1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              restart,
    input  logic [15:0]       restart_pass,
    input  logic              step,
    output logic [DATA_W-1:0] word
);

    localparam logic [DATA_W-1:0] TAPS   = DATA_W'(lfsr_taps(DATA_W));
    localparam logic [DATA_W-1:0] SEED_W = DATA_W'(SEED);
    localparam logic [DATA_W-1:0] BASE_W = DATA_W'(BASE_ADDR);

    logic [DATA_W-1:0] val;
    logic [DATA_W-1:0] pass_w;
    logic [DATA_W-1:0] restart_val;
    logic [DATA_W-1:0] step_val;

    // For XOR the register tracks the low address bits; seed and pass are folded in at the output
    always_comb begin
        restart_val = DATA_W'(restart_pass);
        step_val    = val + DATA_W'(1);
        if (PATTERN == PAT_LFSR) begin
            restart_val = SEED_W ^ DATA_W'(restart_pass);
            step_val    = (val >> 1) ^ (val[0] ? TAPS : '0);
        end else if (PATTERN == PAT_XOR) begin
            restart_val = BASE_W;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            val    <= '0;
            pass_w <= '0;
        end else if (restart) begin
            val    <= restart_val;
            pass_w <= DATA_W'(restart_pass);
        end else if (step) begin
            val <= step_val;
        end
    end

    assign word = (PATTERN == PAT_XOR) ? (val ^ SEED_W ^ pass_w) : val;

endmodule

// File: rtl/ddr3_traffic_checker.sv
// Write-then-read traffic generator/checker for the slowDDR3 user interface:
// fills an address window with a pattern, reads it back and tallies miscompares.
module ddr3_traffic_checker
    import ddr3_tc_pkg::*;
#(
    parameter int unsigned        DATA_W      = 16,
    parameter int unsigned        ADDR_W      = 27,
    parameter logic [ADDR_W-1:0]  BASE_ADDR   = '0,
    parameter int unsigned        WORDS       = 32768,
    parameter int                 PATTERN     = PAT_INC,
    parameter logic [63:0]        SEED        = 64'hACE1,
    parameter int unsigned        PASSES      = 1,
    parameter bit                 STOP_ON_ERR = 1'b1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              init_fin,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [DATA_W-1:0] wr_payload,
    output logic              rd_ready,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_payload,
    output logic [ADDR_W-1:0] address,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              abort,
    output logic [15:0]       err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data,
    output logic [15:0]       pass_cnt
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t            state;
    logic [IDX_W-1:0]  index;
    logic [15:0]       pass_idx;
    logic [DATA_W-1:0] exp_word;
    logic              wr_fire;
    logic              rd_fire;
    logic              last;
    logic              mismatch;
    logic              final_pass;
    logic              gen_restart;
    logic [15:0]       gen_pass;
    logic [ADDR_W-1:0] next_addr;

    // A falling init_fin wins over any handshake on the same edge
    assign wr_fire    = (state == ST_WRITE) && init_fin && wr_ready;
    assign rd_fire    = (state == ST_READ) && init_fin && rd_valid;
    assign last       = (index == LAST_IDX);
    assign mismatch   = rd_fire && (rd_payload != exp_word);
    assign final_pass = (PASSES != 0) && ((32'(pass_idx) + 32'd1) == 32'(PASSES));
    assign next_addr  = BASE_ADDR + ADDR_W'(index) + ADDR_W'(1);

    assign gen_restart = ((state == ST_WAIT_INIT) && init_fin) ||
                         (wr_fire && last) ||
                         (rd_fire && last && !final_pass);
    assign gen_pass    = (state == ST_READ) ? (pass_idx + 16'd1) : pass_idx;

    ddr3_pattern_gen #(
        .DATA_W    (DATA_W),
        .PATTERN   (PATTERN),
        .BASE_ADDR (64'(BASE_ADDR)),
        .SEED      (SEED)
    ) u_gen (
        .clk          (clk),
        .resetn       (resetn),
        .restart      (gen_restart),
        .restart_pass (gen_pass),
        .step         (wr_fire || rd_fire),
        .word         (exp_word)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= ST_IDLE;
            index          <= '0;
            address        <= '0;
            pass_idx       <= '0;
            pass_cnt       <= '0;
            err_cnt        <= '0;
            abort          <= 1'b0;
            first_err_addr <= '0;
            first_err_data <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state          <= ST_WAIT_INIT;
                        index          <= '0;
                        address        <= BASE_ADDR;
                        pass_idx       <= '0;
                        pass_cnt       <= '0;
                        err_cnt        <= '0;
                        abort          <= 1'b0;
                        first_err_addr <= '0;
                        first_err_data <= '0;
                    end
                end
                ST_WAIT_INIT: begin
                    if (init_fin) state <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (!init_fin) begin
                        abort <= 1'b1;
                        state <= ST_DONE;
                    end else if (wr_ready) begin
                        if (last) begin
                            index   <= '0;
                            address <= BASE_ADDR;
                            state   <= ST_READ;
                        end else begin
                            index   <= index + IDX_W'(1);
                            address <= next_addr;
                        end
                    end
                end
                ST_READ: begin
                    if (!init_fin) begin
                        abort <= 1'b1;
                        state <= ST_DONE;
                    end else if (rd_valid) begin
                        // An empty counter means this is the first miscompare of the run
                        if (mismatch) begin
                            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                            if (err_cnt == 16'd0) begin
                                first_err_addr <= address;
                                first_err_data <= rd_payload;
                            end
                        end
                        if (last) begin
                            pass_cnt <= pass_cnt + 16'd1;
                            index    <= '0;
                            address  <= BASE_ADDR;
                        end else begin
                            index    <= index + IDX_W'(1);
                            address  <= next_addr;
                        end
                        if (mismatch && STOP_ON_ERR) begin
                            state <= ST_DONE;
                        end else if (last) begin
                            if (final_pass) begin
                                state <= ST_DONE;
                            end else begin
                                state    <= ST_WRITE;
                                pass_idx <= pass_idx + 16'd1;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign wr_valid   = (state == ST_WRITE);
    assign rd_ready   = (state == ST_READ);
    assign busy       = (state == ST_WAIT_INIT) || (state == ST_WRITE) || (state == ST_READ);
    assign done       = (state == ST_DONE);
    assign pass       = done && (err_cnt == 16'd0) && !abort;
    assign wr_payload = wr_valid ? exp_word : '0;

endmodule

// File: tb/tb_ddr3_traffic_checker.sv
// Directed bench for ddr3_traffic_checker: a cycle table for a clean run plus
// hand sequences for miscompare, multi-pass, LFSR with stalls, abort and reset.
module tb_ddr3_traffic_checker;

    localparam int DW = 16;
    localparam int AW = 27;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Instance A: WORDS=8, incrementing, stop on first error, one pass
    logic           start_a = 1'b0, init_fin_a = 1'b1, corrupt_a = 1'b0;
    logic           wr_valid_a, wr_ready_a, rd_ready_a, rd_valid_a;
    logic [DW-1:0]  wr_payload_a, rd_payload_a, first_err_data_a;
    logic [AW-1:0]  address_a, first_err_addr_a;
    logic           busy_a, done_a, pass_a, abort_a;
    logic [15:0]    err_cnt_a, pass_cnt_a;
    logic [DW-1:0]  mem_a [8];

    assign wr_ready_a   = 1'b1;
    assign rd_valid_a   = 1'b1;
    assign rd_payload_a = mem_a[address_a[2:0]] ^ ((corrupt_a && address_a == 27'd5) ? 16'd1 : 16'd0);
    always @(posedge clk) if (wr_valid_a && wr_ready_a) mem_a[address_a[2:0]] <= wr_payload_a;

    ddr3_traffic_checker #(.DATA_W(DW), .ADDR_W(AW), .WORDS(8), .PATTERN(0), .PASSES(1), .STOP_ON_ERR(1'b1)) dut_a (
        .clk(clk), .resetn(resetn), .start(start_a), .init_fin(init_fin_a),
        .wr_valid(wr_valid_a), .wr_ready(wr_ready_a), .wr_payload(wr_payload_a),
        .rd_ready(rd_ready_a), .rd_valid(rd_valid_a), .rd_payload(rd_payload_a),
        .address(address_a), .busy(busy_a), .done(done_a), .pass(pass_a), .abort(abort_a),
        .err_cnt(err_cnt_a), .first_err_addr(first_err_addr_a), .first_err_data(first_err_data_a),
        .pass_cnt(pass_cnt_a));

    // Instance B: same window, corrupt read at address 5, keep going, two passes
    logic           start_b = 1'b0, init_fin_b = 1'b1;
    logic           wr_valid_b, wr_ready_b, rd_ready_b, rd_valid_b;
    logic [DW-1:0]  wr_payload_b, rd_payload_b, first_err_data_b;
    logic [AW-1:0]  address_b, first_err_addr_b;
    logic           busy_b, done_b, pass_b, abort_b;
    logic [15:0]    err_cnt_b, pass_cnt_b;
    logic [DW-1:0]  mem_b [8];
    int             wcnt_b = 0, wr_err_b = 0;

    assign wr_ready_b   = 1'b1;
    assign rd_valid_b   = 1'b1;
    assign rd_payload_b = mem_b[address_b[2:0]] ^ ((address_b == 27'd5) ? 16'd1 : 16'd0);

    // Word i of pass p must be i+p at address i
    always @(posedge clk) begin
        if (wr_valid_b && wr_ready_b) begin
            mem_b[address_b[2:0]] <= wr_payload_b;
            if (wr_payload_b !== 16'(wcnt_b % 8 + wcnt_b / 8) || address_b !== 27'(wcnt_b % 8))
                wr_err_b <= wr_err_b + 1;
            wcnt_b <= wcnt_b + 1;
        end
    end

    ddr3_traffic_checker #(.DATA_W(DW), .ADDR_W(AW), .WORDS(8), .PATTERN(0), .PASSES(2), .STOP_ON_ERR(1'b0)) dut_b (
        .clk(clk), .resetn(resetn), .start(start_b), .init_fin(init_fin_b),
        .wr_valid(wr_valid_b), .wr_ready(wr_ready_b), .wr_payload(wr_payload_b),
        .rd_ready(rd_ready_b), .rd_valid(rd_valid_b), .rd_payload(rd_payload_b),
        .address(address_b), .busy(busy_b), .done(done_b), .pass(pass_b), .abort(abort_b),
        .err_cnt(err_cnt_b), .first_err_addr(first_err_addr_b), .first_err_data(first_err_data_b),
        .pass_cnt(pass_cnt_b));

    // Instance C: LFSR pattern over 16 words with random handshake stalls
    logic           start_c = 1'b0, init_fin_c = 1'b1;
    logic           wr_valid_c, wr_ready_c, rd_ready_c, rd_valid_c;
    logic [DW-1:0]  wr_payload_c, rd_payload_c, first_err_data_c;
    logic [AW-1:0]  address_c, first_err_addr_c;
    logic           busy_c, done_c, pass_c, abort_c;
    logic [15:0]    err_cnt_c, pass_cnt_c;
    logic [DW-1:0]  mem_c [16];
    logic [15:0]    lfsr_c = 16'hACE1;
    int             wcnt_c = 0, wr_err_c = 0;

    assign rd_payload_c = mem_c[address_c[3:0]];

    always @(negedge clk) begin
        wr_ready_c <= ($urandom_range(0, 3) != 0);
        rd_valid_c <= ($urandom_range(0, 3) != 0);
    end

    always @(posedge clk) begin
        if (wr_valid_c && wr_ready_c) begin
            mem_c[address_c[3:0]] <= wr_payload_c;
            if (wr_payload_c !== lfsr_c || address_c !== 27'(wcnt_c)) wr_err_c <= wr_err_c + 1;
            lfsr_c <= {1'b0, lfsr_c[15:1]} ^ (lfsr_c[0] ? 16'hB400 : 16'h0000);
            wcnt_c <= wcnt_c + 1;
        end
    end

    ddr3_traffic_checker #(.DATA_W(DW), .ADDR_W(AW), .WORDS(16), .PATTERN(1), .PASSES(1), .STOP_ON_ERR(1'b1)) dut_c (
        .clk(clk), .resetn(resetn), .start(start_c), .init_fin(init_fin_c),
        .wr_valid(wr_valid_c), .wr_ready(wr_ready_c), .wr_payload(wr_payload_c),
        .rd_ready(rd_ready_c), .rd_valid(rd_valid_c), .rd_payload(rd_payload_c),
        .address(address_c), .busy(busy_c), .done(done_c), .pass(pass_c), .abort(abort_c),
        .err_cnt(err_cnt_c), .first_err_addr(first_err_addr_c), .first_err_data(first_err_data_c),
        .pass_cnt(pass_cnt_c));

    typedef struct {
        logic          start;
        logic          init_fin;
        logic [5:0]    exp_flags;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_payload;
    } vec_t;

    vec_t vecs[18];

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        start_a    = v.start;
        init_fin_a = v.init_fin;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_a(input string tag);
        check_output({tag, "_flags"}, 64'({wr_valid_a, rd_ready_a, busy_a, done_a, pass_a, abort_a}), 64'd0);
        check_output({tag, "_counts"}, 64'({err_cnt_a, pass_cnt_a}), 64'd0);
        check_output({tag, "_addr"}, 64'({address_a, first_err_addr_a}), 64'd0);
        check_output({tag, "_data"}, 64'({wr_payload_a, first_err_data_a}), 64'd0);
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
    endtask

    initial begin
        int n;

        // Cycle table for a clean run: flags = {busy, done, pass, wr_valid, rd_ready, abort}
        vecs[0] = '{start: 1'b1, init_fin: 1'b1, exp_flags: 6'b100000, exp_addr: '0, exp_payload: '0};
        for (int k = 0; k < 8; k++) begin
            vecs[1 + k] = '{start: 1'b0, init_fin: 1'b1, exp_flags: 6'b100100, exp_addr: AW'(k), exp_payload: DW'(k)};
            vecs[9 + k] = '{start: 1'b0, init_fin: 1'b1, exp_flags: 6'b100010, exp_addr: AW'(k), exp_payload: '0};
        end
        vecs[17] = '{start: 1'b0, init_fin: 1'b1, exp_flags: 6'b011000, exp_addr: '0, exp_payload: '0};

        #12;
        check_reset_a("reset");
        #10;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("vec%0d_flags", i),
                         64'({busy_a, done_a, pass_a, wr_valid_a, rd_ready_a, abort_a}), 64'(vecs[i].exp_flags));
            if (vecs[i].exp_flags[2] || vecs[i].exp_flags[1])
                check_output($sformatf("vec%0d_addr", i), 64'(address_a), 64'(vecs[i].exp_addr));
            if (vecs[i].exp_flags[2])
                check_output($sformatf("vec%0d_payload", i), 64'(wr_payload_a), 64'(vecs[i].exp_payload));
        end
        check_output("clean_err_cnt", 64'(err_cnt_a), 64'd0);
        check_output("clean_pass_cnt", 64'(pass_cnt_a), 64'd1);

        // Miscompare at address 5 ends the run immediately
        corrupt_a = 1'b1;
        pulse_start_a();
        n = 0;
        while (!done_a && n < 100) begin @(posedge clk); #1; n++; end
        check_output("stop_done", 64'(done_a), 64'd1);
        check_output("stop_pass", 64'(pass_a), 64'd0);
        check_output("stop_rd_ready", 64'(rd_ready_a), 64'd0);
        check_output("stop_err_cnt", 64'(err_cnt_a), 64'd1);
        check_output("stop_first_addr", 64'(first_err_addr_a), 64'd5);
        check_output("stop_first_data", 64'(first_err_data_a), 64'd4);
        check_output("stop_pass_cnt", 64'(pass_cnt_a), 64'd0);
        corrupt_a = 1'b0;

        // init_fin drops while the fourth write is presented
        pulse_start_a();
        n = 0;
        while (!(wr_valid_a && address_a == 27'd3) && n < 100) begin @(posedge clk); #1; n++; end
        check_output("abort_reach_w3", 64'(wr_valid_a && address_a == 27'd3), 64'd1);
        init_fin_a = 1'b0;
        @(posedge clk);
        #1;
        check_output("abort_flags", 64'({wr_valid_a, abort_a, done_a, pass_a}), 64'b0110);
        init_fin_a = 1'b1;

        // Two passes, errors counted but not fatal
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        n = 0;
        while (!done_b && n < 200) begin @(posedge clk); #1; n++; end
        check_output("multi_done", 64'(done_b), 64'd1);
        check_output("multi_pass", 64'(pass_b), 64'd0);
        check_output("multi_err_cnt", 64'(err_cnt_b), 64'd2);
        check_output("multi_pass_cnt", 64'(pass_cnt_b), 64'd2);
        check_output("multi_first_addr", 64'(first_err_addr_b), 64'd5);
        check_output("multi_first_data", 64'(first_err_data_b), 64'd4);
        check_output("multi_writes", 64'(wcnt_b), 64'd16);
        check_output("multi_wr_data", 64'(wr_err_b), 64'd0);

        // LFSR pattern with stalls on both handshakes
        start_c = 1'b1;
        @(posedge clk);
        #1;
        start_c = 1'b0;
        n = 0;
        while (!done_c && n < 1000) begin @(posedge clk); #1; n++; end
        check_output("lfsr_done", 64'(done_c), 64'd1);
        check_output("lfsr_pass", 64'(pass_c), 64'd1);
        check_output("lfsr_err_cnt", 64'(err_cnt_c), 64'd0);
        check_output("lfsr_writes", 64'(wcnt_c), 64'd16);
        check_output("lfsr_wr_data", 64'(wr_err_c), 64'd0);

        // Asynchronous reset in the middle of the read phase, then a clean rerun
        pulse_start_a();
        n = 0;
        while (!(rd_ready_a && address_a == 27'd4) && n < 100) begin @(posedge clk); #1; n++; end
        check_output("rst_reach_read", 64'(rd_ready_a && address_a == 27'd4), 64'd1);
        #2;
        resetn = 1'b0;
        #1;
        check_reset_a("mid_read_reset");
        #2;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        pulse_start_a();
        n = 0;
        while (!done_a && n < 100) begin @(posedge clk); #1; n++; end
        check_output("rerun_done", 64'(done_a), 64'd1);
        check_output("rerun_pass", 64'(pass_a), 64'd1);
        check_output("rerun_pass_cnt", 64'(pass_cnt_a), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
